// File: rtl/gpio_pkg.sv
// Shared constants and types for the memory-mapped GPIO responder.
package gpio_pkg;

    localparam int unsigned N_SW = 10;

    // Register select, decoded from DataAdr[3:2]
    typedef enum logic [1:0] {
        OFF_LED  = 2'd0,
        OFF_SW   = 2'd1,
        OFF_EDGE = 2'd2,
        OFF_CYC  = 2'd3
    } reg_sel_t;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchronizer followed by a stability debouncer.
// Debouncer is built only when MMIO_GPIO_DEBOUNCE_EN is defined; otherwise stable follows s2.
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic level,
    output logic rise
);

    logic s1, s2, stable;

    if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_deb_range
        $error("sw_debounce: DEB_CYCLES must be in 1..65535");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

`ifdef MMIO_GPIO_DEBOUNCE_EN
    logic [15:0] cnt;
    logic        done;

    // done marks the edge on which stable takes the new level
    assign done = (s2 != stable) && (cnt == 16'(DEB_CYCLES - 1));
    assign rise = done & s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (done) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign rise = s2 & ~stable;

    always_ff @(posedge clk) begin
        if (reset) stable <= 1'b0;
        else       stable <= s2;
    end
`endif

    assign level = stable;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED register, debounced switches, W1C rising-edge latch, cycle counter.
// Debounce is enabled by defining MMIO_GPIO_DEBOUNCE_EN (see sw_debounce).
module mmio_gpio
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              hit,
    input  logic [N_SW-1:0]   switches,
    output logic [N_SW-1:0]   leds
);

    reg_sel_t         sel;
    logic             we;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  edge_q;
    logic [N_SW-1:0]  edge_clr;
    logic [31:0]      cyc;
    logic             unused_adr_lsb;

    if (BASE_ADDR[3:0] != 4'h0) begin : g_base_align
        $error("mmio_gpio: BASE_ADDR[3:0] must be zero");
    end

    assign hit = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign sel = reg_sel_t'(DataAdr[3:2]);
    assign we  = MemWrite & hit;
    assign unused_adr_lsb = ^DataAdr[1:0];

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .sw_raw (switches[i]),
            .level  (sw_level[i]),
            .rise   (sw_rise[i])
        );
    end

    assign edge_clr = (we && sel == OFF_EDGE) ? WriteData[N_SW-1:0] : '0;

    // A rise landing on the same edge as a W1C clear keeps the bit set
    always_ff @(posedge clk) begin
        if (reset) begin
            leds   <= '0;
            edge_q <= '0;
            cyc    <= '0;
        end else begin
            if (we && sel == OFF_LED) leds <= WriteData[N_SW-1:0];
            edge_q <= (edge_q & ~edge_clr) | sw_rise;
            cyc    <= (we && sel == OFF_CYC) ? WriteData : cyc + 32'd1;
        end
    end

    always_comb begin
        ReadData = '0;
        if (hit) begin
            unique case (sel)
                OFF_LED:  ReadData = {{(32-N_SW){1'b0}}, leds};
                OFF_SW:   ReadData = {{(32-N_SW){1'b0}}, sw_level};
                OFF_EDGE: ReadData = {{(32-N_SW){1'b0}}, edge_q};
                OFF_CYC:  ReadData = cyc;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio against a behavioural register/switch model.
module tb_mmio_gpio;

    localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef MMIO_GPIO_DEBOUNCE_EN
    localparam int EFF_DEB = 16;
`else
    localparam int EFF_DEB = 1;
`endif

    logic        clk, reset, MemWrite, hit;
    logic [31:0] DataAdr, WriteData, ReadData;
    logic [9:0]  switches, leds;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [9:0]  m_s1 = '0, m_s2 = '0, m_stable = '0, m_leds = '0, m_edge = '0;
    logic [31:0] m_cyc = '0;
    int          m_run[10];

    mmio_gpio #(
        .BASE_ADDR  (BASE),
        .DEB_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .switches  (switches),
        .leds      (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return {22'h0, m_leds};
            2'd1:    return {22'h0, m_stable};
            2'd2:    return {22'h0, m_edge};
            default: return m_cyc;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        logic [9:0] rise;
        logic [9:0] nstable;
        logic [9:0] clr;
        logic       w;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_leds = '0; m_edge = '0; m_cyc = '0;
            for (int i = 0; i < 10; i++) m_run[i] = 0;
        end else begin
            rise = '0;
            nstable = m_stable;
            for (int i = 0; i < 10; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= EFF_DEB) begin
                        nstable[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_s2[i]) rise[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            w = MemWrite && m_hit(DataAdr);
            clr = (w && DataAdr[3:2] == 2'd2) ? WriteData[9:0] : 10'h0;
            if (w && DataAdr[3:2] == 2'd0) m_leds = WriteData[9:0];
            m_cyc = (w && DataAdr[3:2] == 2'd3) ? WriteData : m_cyc + 32'd1;
            m_edge = (m_edge & ~clr) | rise;
            m_stable = nstable;
            m_s2 = m_s1;
            m_s1 = switches;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DataAdr = a; WriteData = d; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        DataAdr = a;
        #1;
        check(tag, ReadData, mread(a));
    endtask

    task automatic rd_const(input string tag, input logic [31:0] a, input logic [31:0] exp);
        DataAdr = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        int lat;
        logic [31:0] cexp[4];
        for (int i = 0; i < 10; i++) m_run[i] = 0;
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; switches = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state and LED write
        check("rst_leds", leds, 32'h0);
        rd_const("rst_led", BASE + 32'h0, 32'h0);
        rd_const("rst_sw", BASE + 32'h4, 32'h0);
        rd_const("rst_edge", BASE + 32'h8, 32'h0);
        wr(BASE, 32'h3A5);
        check("led_out", leds, 32'h3A5);
        rd_const("led_rb", BASE, 32'h3A5);
        wr(BASE, 32'hFFFF_FFFF);
        rd_const("led_rb_mask", BASE, 32'h3FF);

        // Debounce latency on switch 3
        switches[3] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            rd("sw3_track", BASE + 32'h4);
            if (ReadData[3] && lat == 0) lat = c;
        end
        check("sw3_latency", lat, EFF_DEB + 2);
        rd_const("edge_sw3", BASE + 32'h8, 32'h008);

        // Short pulse on switch 5
        switches[5] = 1'b1;
        for (int c = 0; c < 10; c++) begin tick(); rd("glitch_sw", BASE + 32'h4); end
        switches[5] = 1'b0;
        for (int c = 0; c < 24; c++) begin tick(); rd("glitch_settle", BASE + 32'h4); end
        rd("glitch_edge", BASE + 32'h8);
`ifdef MMIO_GPIO_DEBOUNCE_EN
        rd_const("glitch_sw_hold", BASE + 32'h4, 32'h008);
        rd_const("glitch_edge_hold", BASE + 32'h8, 32'h008);
`endif
        wr(BASE + 32'h8, 32'h3F7);
        rd_const("edge_w1c_others", BASE + 32'h8, 32'h008);

        // W1C on a settled edge, then collision with a fresh rise
        switches[0] = 1'b1;
        for (int c = 0; c < 24; c++) tick();
        rd_const("edge_009", BASE + 32'h8, 32'h009);
        wr(BASE + 32'h8, 32'h001);
        rd_const("edge_w1c", BASE + 32'h8, 32'h008);
        switches[0] = 1'b0;
        for (int c = 0; c < 24; c++) tick();
        switches[0] = 1'b1;
        for (int c = 0; c < EFF_DEB + 1; c++) tick();
        wr(BASE + 32'h8, 32'h001);
        rd_const("edge_collide", BASE + 32'h8, 32'h009);
        rd("edge_collide_m", BASE + 32'h8);

        // CYC load and wrap
        rd("cyc_free", BASE + 32'hC);
        wr(BASE + 32'hC, 32'hFFFF_FFFE);
        cexp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        for (int j = 0; j < 4; j++) begin
            rd_const("cyc_wrap", BASE + 32'hC, cexp[j]);
            tick();
        end

        // Address misses and byte-offset alias
        DataAdr = 32'h410; WriteData = 32'h155; MemWrite = 1'b1;
        #1;
        check("miss_hi_hit", hit, 32'h0);
        check("miss_hi_rd", ReadData, 32'h0);
        tick();
        DataAdr = 32'h3FC;
        #1;
        check("miss_lo_hit", hit, 32'h0);
        check("miss_lo_rd", ReadData, 32'h0);
        tick();
        MemWrite = 1'b0;
        check("miss_leds", leds, 32'h3FF);
        rd_const("alias_rd", BASE + 32'h2, 32'h3FF);
        wr(BASE + 32'h3, 32'h155);
        check("alias_wr", leds, 32'h155);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            int r;
            if ($urandom_range(5) == 0) switches ^= 10'(1 << $urandom_range(9));
            r = $urandom_range(7);
            if (r < 6)       DataAdr = BASE + $urandom_range(15);
            else if (r == 6) DataAdr = BASE + 32'h10 + $urandom_range(63);
            else             DataAdr = $urandom;
            MemWrite = ($urandom_range(3) == 0);
            WriteData = $urandom;
            #1;
            check("rand_hit", hit, m_hit(DataAdr));
            check("rand_rd", ReadData, mread(DataAdr));
            check("rand_leds", leds, m_leds);
            tick();
        end
        MemWrite = 1'b0;

        // Reset in the middle of a debounce and a pending CYC write
        switches = '0;
        for (int c = 0; c < 24; c++) tick();
        switches = 10'h3FF;
        for (int c = 0; c < EFF_DEB / 2 + 2; c++) tick();
        wr(BASE + 32'hC, 32'h1234);
        rd_const("cyc_pre_rst", BASE + 32'hC, 32'h1234);
        DataAdr = BASE + 32'hC; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; MemWrite = 1'b0;
        check("mid_rst_leds", leds, 32'h0);
        rd_const("mid_rst_sw", BASE + 32'h4, 32'h0);
        rd_const("mid_rst_edge", BASE + 32'h8, 32'h0);
        rd_const("mid_rst_cyc", BASE + 32'hC, 32'h0);
        lat = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            rd("post_rst_sw", BASE + 32'h4);
            if (ReadData == 32'h3FF && lat == 0) lat = c;
        end
        check("post_rst_latency", lat, EFF_DEB + 2);
        rd_const("post_rst_edge", BASE + 32'h8, 32'h3FF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Memory-mapped GPIO responder on the processor data bus: it answers the `MemWrite`/`DataAdr`/`WriteData`/`ReadData` accesses the ARM core issues, next to RAM in the unified memory. It owns the board LED register, synchronizes and debounces the slide switches, latches rising edges per switch, and provides a free-running cycle counter. The memory block muxes its `ReadData` into the core using `hit`.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: window base; bits [3:0] must be zero.
- `DEB_CYCLES`, default 16: debounce stability length in cycles; allowed range 1..65535.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MemWrite` in 1: write strobe from the core.
- `DataAdr` in 32: byte address.
- `WriteData` in 32: write data.
- `ReadData` out 32: read data, combinational.
- `hit` out 1: combinational; high when `DataAdr[31:4] == BASE_ADDR[31:4]`.
- `switches` in 10: raw asynchronous board switches.
- `leds` out 10: LED drive, registered.

## Operation
- Decoding uses `DataAdr[3:2]`. `DataAdr[1:0]` is ignored, so no misalignment faults are raised.
- Register map, as offsets from `BASE_ADDR`:
  - 0x0 `LED`: RW. Bits [9:0] hold the LED value. Upper bits read 0.
  - 0x4 `SW`: RO. Bits [9:0] hold the debounced switch level. Writes are ignored.
  - 0x8 `EDGE`: W1C. A bit sets on each 0→1 transition of the debounced level. Writing 1 clears that bit.
  - 0xC `CYC`: RW. A 32-bit cycle counter. A write loads it.
- **Write qualification:** a write takes effect on the rising edge where `MemWrite & hit` is true.
- **Reads:**
  - `ReadData` is the addressed register whenever `hit` is true, independent of `MemWrite`.
  - `ReadData` is 32'h0 when `hit` is false.
- **Switch path:**
  - Each bit passes through a two-flop synchronizer, `s1` then `s2`.
  - A per-bit debouncer then drives `stable`.
- **Debouncer, per bit:**
  - Counter `cnt` is 16 bits wide.
  - If `s2 == stable`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEB_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - A glitch shorter than `DEB_CYCLES` cycles never reaches `stable`.
- **EDGE bit i:**
  - It sets on the same edge where `stable[i]` goes 0→1.
  - When a set and a W1C clear of the same bit coincide, the set wins.
  - Falling transitions do not set the bit.
- **CYC:**
  - It increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - On a write cycle it loads `WriteData` instead of incrementing.
- **Reset values:** `leds`, `s1`, `s2`, `stable`, `cnt`, `EDGE` and `CYC` are all 0. `ReadData` follows the combinational rule.
- **Reset mid-operation:** reset overrides any write or count in progress on that edge.

## Timing
- **Switch-to-SW latency:** a raw switch change set up before edge k is handled as follows.
  - `s2` reflects it after edge k+1.
  - `stable` updates at edge k+1+`DEB_CYCLES`, if `s2` holds for the whole interval.
- **Register timing:**
  - `SW` and `EDGE` become readable in the cycle after the updating edge.
  - A `LED` write is visible on `leds` and on readback the cycle after the write edge.
  - A read of `CYC` returns the current count. After a write of V, the next cycle reads V and the cycle after reads V+1.
- **Read latency:** zero wait states. The single-cycle core samples `ReadData` in the same cycle.

## Configuration
- Macro: `MMIO_GPIO_DEBOUNCE_EN`.
- **Defined:** the debouncer operates as described; `DEB_CYCLES` applies.
- **Undefined:**
  - The debouncer is omitted, the `cnt` registers are not built, and `DEB_CYCLES` is ignored.
  - The behaviour is `stable <= s2` every cycle, so `SW` is updated at edge k+2.
  - This matches the defined-macro timing with `DEB_CYCLES`=1.

## Structure
- **Package `gpio_pkg`:**
  - `N_SW` = 10.
  - Offset constants `OFF_LED`, `OFF_SW`, `OFF_EDGE`, `OFF_CYC`, expressed in `DataAdr[3:2]` encodings 0..3.
  - A typedef for the 2-bit register select.
- **Sub-module `sw_debounce`:**
  - One bit wide, parameterized by `DEB_CYCLES`.
  - Contains its synchronizer and debouncer, plus the macro guard.
  - Instantiated `N_SW` times in a generate loop.
- **Top level:** decode, the register file, EDGE logic, CYC and the read mux remain in `mmio_gpio`.

## Test plan
- **Reset and LED write:**
  - Stimulus: assert reset for 2 cycles; read 0x400, 0x404, 0x408; write 0x3A5 to 0x400 with `MemWrite`.
  - Required response: the reads return 0, 0 and 0; `leds`=0x3A5 the next cycle; a readback returns 0x3A5.
  - Stimulus: write 0xFFFF_FFFF to 0x400. Required response: readback is 0x3FF.
- **Debounce and glitch (`DEB_CYCLES`=16):**
  - Stimulus: raise `switches[3]` at edge k. Required response: `SW` bit 3 sets at edge k+17 and `EDGE`=0x008.
  - Stimulus: a 10-cycle pulse on `switches[5]`. Required response: `SW` and `EDGE` are unchanged.
- **W1C collision:**
  - Stimulus: with `EDGE`=0x009, write 0x001 to 0x408. Required response: `EDGE`=0x008.
  - Stimulus: write 0x001 on the same edge that `stable[0]` rises again. Required response: bit 0 stays 1.
- **CYC load and wrap:**
  - Stimulus: write 0xFFFF_FFFE to 0x40C.
  - Required response: successive reads return 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
- **Address miss:**
  - Stimulus: `DataAdr`=0x410 or 0x3FC with `MemWrite`=1 and data 0x155.
  - Required response: `hit`=0, `ReadData`=0, and `leds` is unchanged.
  - Stimulus: `DataAdr`=0x402. Required response: aliases to `LED`.
- **Reset mid-operation:**
  - Stimulus: assert reset while `switches`=0x3FF, a debounce is half complete and `CYC`=0x1234 with a write pending.
  - Required response: all state reads 0 after the edge.
  - Required response after release: `SW`=0x3FF is reached at edge release+17 and `EDGE`=0x3FF.
